// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment map used by the 7-segment display stages.
//   nibble_t      4-bit hex digit
//   seg_t         7-bit active-high segment vector, bit 0 = a .. bit 6 = g
//   scan_state_e  scan slot phase: BLANK (dark gap) or SHOW
//   SEG_BLANK     all segments off
//   hex_to_seg    nibble -> segment pattern (gfedcba)
package seg7_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam seg_t SEG_BLANK = 7'h00;

  // Hex digit to segment pattern, lower-case b and d to keep them distinct from 8 and 0.
  function automatic seg_t hex_to_seg(input nibble_t value);
    seg_t pattern;
    case (value)
      4'h0:    pattern = 7'h3F;
      4'h1:    pattern = 7'h06;
      4'h2:    pattern = 7'h5B;
      4'h3:    pattern = 7'h4F;
      4'h4:    pattern = 7'h66;
      4'h5:    pattern = 7'h6D;
      4'h6:    pattern = 7'h7D;
      4'h7:    pattern = 7'h07;
      4'h8:    pattern = 7'h7F;
      4'h9:    pattern = 7'h6F;
      4'hA:    pattern = 7'h77;
      4'hB:    pattern = 7'h7C;
      4'hC:    pattern = 7'h39;
      4'hD:    pattern = 7'h5E;
      4'hE:    pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to 7-segment decoder.
//   digit  in   4  hex value
//   seg    out  7  active-high segments, seg[0]=a .. seg[6]=g
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(digit);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver.
// Holds NUM_DIGITS hex digits and scans them onto one shared segment bus, one slot
// of PRESCALE cycles per digit, the first BLANK_CYCLES of each slot dark to avoid ghosting.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading-zero digits above digit 0).
//   clk      in   1           system clock, rising edge
//   rst_n    in   1           synchronous active-low reset
//   wr_en    in   1           digit register write strobe
//   wr_addr  in   3           digit index to write, 0 = least significant
//   wr_data  in   4           hex value to store
//   seg      out  7           active-high segments, seg[0]=a .. seg[6]=g
//   dig_en   out  NUM_DIGITS  one-hot active-high digit enable, zero while blanking
//   frame    out  1           pulse on the last cycle of the final digit's slot
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 8,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [3:0]            wr_data,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = $clog2(PRESCALE);

  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD      = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(NUM_DIGITS - 1);

  nibble_t          digits [NUM_DIGITS];
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  scan_state_e      state;
  nibble_t          shadow;
  logic             suppress;

  logic [CNT_W-1:0]      cnt_nxt;
  logic [IDX_W-1:0]      idx_nxt;
  scan_state_e           state_nxt;
  nibble_t               shadow_nxt;
  logic                  suppress_nxt;
  logic                  load_c;
  logic                  lz_blank_c;
  logic                  lit_c;
  seg_t                  seg_dec_c;
  seg_t                  seg_nxt;
  logic [NUM_DIGITS-1:0] dig_en_nxt;
  logic                  frame_nxt;
  logic                  wr_ok_c;

  // Leading-zero detection for the digit about to be shown.
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic zero_hi;
    zero_hi = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (IDX_W'(j) >= idx && digits[j] != 4'h0) begin
        zero_hi = 1'b0;
      end
    end
    lz_blank_c = (idx != '0) && zero_hi;
  end
`else
  always_comb begin
    lz_blank_c = 1'b0;
  end
`endif

  // Slot counter, scan index, phase and shadow next-state.
  always_comb begin
    cnt_nxt      = cnt + CNT_W'(1);
    idx_nxt      = idx;
    state_nxt    = state;
    load_c       = 1'b0;
    shadow_nxt   = shadow;
    suppress_nxt = suppress;

    if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end

    case (state)
      BLANK: begin
        if (cnt == CNT_LOAD) begin
          state_nxt = SHOW;
          load_c    = 1'b1;
        end
      end
      SHOW: begin
        if (cnt == CNT_LAST) begin
          state_nxt = BLANK;
        end
      end
      default: state_nxt = BLANK;
    endcase

    // Digit array is read before this edge's write lands, so a coinciding write loads the old value.
    if (load_c) begin
      shadow_nxt   = digits[idx];
      suppress_nxt = lz_blank_c;
    end
  end

  // Decoder sits on the next-shadow value so seg lines up with the first SHOW cycle.
  seg7_hex_decode u_hex_decode (
    .digit (shadow_nxt),
    .seg   (seg_dec_c)
  );

  // Output next values, computed from next state so the registers are aligned with cnt.
  always_comb begin
    lit_c      = (state_nxt == SHOW) && !suppress_nxt;
    seg_nxt    = SEG_BLANK;
    dig_en_nxt = '0;
    if (lit_c) begin
      seg_nxt    = seg_dec_c;
      dig_en_nxt = NUM_DIGITS'(1) << idx_nxt;
    end
    frame_nxt = (idx_nxt == IDX_LAST) && (cnt_nxt == CNT_LAST);
    wr_ok_c   = wr_en && (32'(wr_addr) < NUM_DIGITS);
  end

  // State, digit file and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digits[i] <= '0;
      end
      cnt      <= '0;
      idx      <= '0;
      state    <= BLANK;
      shadow   <= '0;
      suppress <= 1'b0;
      seg      <= SEG_BLANK;
      dig_en   <= '0;
      frame    <= 1'b0;
    end else begin
      if (wr_ok_c) begin
        digits[wr_addr[IDX_W-1:0]] <= wr_data;
      end
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      state    <= state_nxt;
      shadow   <= shadow_nxt;
      suppress <= suppress_nxt;
      seg      <= seg_nxt;
      dig_en   <= dig_en_nxt;
      frame    <= frame_nxt;
    end
  end

endmodule
